// File: rtl/bram_pingpong_ctrl.sv
// bram_pingpong_ctrl: write sequencer for a ping-pong pair of register-buffer banks.
// Fills one bank from a valid/ready stream while the other, full bank is held for the consumer.
// Optional feature macro: BRAM_PP_STATUS_EN (adds bank_cnt and overrun_err).
// Ports:
//   clka, rst_na        clock, asynchronous active-low reset
//   flush               synchronous abort of all bank state
//   s_valid/s_data      input stream, s_ready accept handshake
//   addra/dina          shared write address and data for both banks
//   wea0/wea1           per-bank write enables
//   rd_valid/rd_sel     full bank presented to the consumer
//   rd_release          consumer done with bank rd_sel
//   bank_cnt            honoured releases (status build only)
//   overrun_err         sticky: stream pushed while stalled (status build only)
module bram_pingpong_ctrl #(
  parameter int RAM_WIDTH = 16,
  parameter int RAM_DEPTH = 11
) (
  input  logic                         clka,
  input  logic                         rst_na,
  input  logic                         flush,
  input  logic                         s_valid,
  input  logic [RAM_WIDTH-1:0]         s_data,
  output logic                         s_ready,
  output logic [$clog2(RAM_DEPTH)-1:0] addra,
  output logic [RAM_WIDTH-1:0]         dina,
  output logic                         wea0,
  output logic                         wea1,
  output logic                         rd_valid,
  output logic                         rd_sel,
  input  logic                         rd_release
`ifdef BRAM_PP_STATUS_EN
  ,
  output logic [15:0]                  bank_cnt,
  output logic [0:0]                   overrun_err
`endif
);
  // $clog2(RAM_DEPTH) equals the bank's clogb2(RAM_DEPTH-1) for RAM_DEPTH >= 2
  localparam int ADDR_W = $clog2(RAM_DEPTH);
  localparam logic [0:0] FILL  = 1'b0;
  localparam logic [0:0] STALL = 1'b1;

  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic              r_wr_bank;
  logic [1:0]        r_full;
  logic              r_set_pend;
  logic              r_set_bank;
  logic              w_accept;
  logic              w_last;
  logic              w_release;
  logic              w_wr_bank_nxt;
  logic [1:0]        w_full_nxt;

  assign s_ready       = rst_na & ~flush & (r_state == FILL) & ~r_full[r_wr_bank];
  assign w_accept      = s_valid & s_ready;
  assign w_last        = r_wr_ptr == ADDR_W'(RAM_DEPTH - 1);
  assign rd_valid      = r_full[rd_sel];
  assign w_release     = rd_release & rd_valid & ~flush;
  assign w_wr_bank_nxt = r_wr_bank ^ (w_accept & w_last);
  // full is marked one edge after the last write is issued, so the bank has stored it;
  // the set and the release always hit different banks
  assign w_full_nxt    = (r_full | (r_set_pend ? 2'b01 << r_set_bank : 2'b00))
                       & ~(w_release ? 2'b01 << rd_sel : 2'b00);

  always_ff @(posedge clka or negedge rst_na) begin
    if (!rst_na) begin
      addra      <= '0;
      dina       <= '0;
      wea0       <= 1'b0;
      wea1       <= 1'b0;
      rd_sel     <= 1'b0;
      r_state    <= FILL;
      r_wr_ptr   <= '0;
      r_wr_bank  <= 1'b0;
      r_full     <= 2'b00;
      r_set_pend <= 1'b0;
      r_set_bank <= 1'b0;
    end else if (flush) begin
      wea0       <= 1'b0;
      wea1       <= 1'b0;
      rd_sel     <= 1'b0;
      r_state    <= FILL;
      r_wr_ptr   <= '0;
      r_wr_bank  <= 1'b0;
      r_full     <= 2'b00;
      r_set_pend <= 1'b0;
      r_set_bank <= 1'b0;
    end else begin
      wea0 <= w_accept & ~r_wr_bank;
      wea1 <= w_accept & r_wr_bank;
      if (w_accept) begin
        addra    <= r_wr_ptr;
        dina     <= s_data;
        r_wr_ptr <= w_last ? '0 : r_wr_ptr + 1'b1;
      end
      r_wr_bank  <= w_wr_bank_nxt;
      r_set_pend <= w_accept & w_last;
      r_set_bank <= r_wr_bank;
      r_full     <= w_full_nxt;
      rd_sel     <= rd_sel ^ w_release;
      r_state    <= w_full_nxt[w_wr_bank_nxt] ? STALL : FILL;
    end
  end

`ifdef BRAM_PP_STATUS_EN
  always_ff @(posedge clka or negedge rst_na) begin
    if (!rst_na) begin
      bank_cnt    <= '0;
      overrun_err <= 1'b0;
    end else if (flush) begin
      bank_cnt    <= '0;
      overrun_err <= 1'b0;
    end else begin
      bank_cnt <= bank_cnt + 16'(w_release);
      if (s_valid && r_state == STALL) overrun_err <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_bram_pingpong_ctrl.sv
// tb_bram_pingpong_ctrl: directed self-checking bench for bram_pingpong_ctrl.
module tb_bram_pingpong_ctrl;
  logic        clka = 1'b0;
  logic        rst_na = 1'b0;
  logic        flush = 1'b0;
  logic        s_valid = 1'b0;
  logic [15:0] s_data = '0;
  logic        s_ready;
  logic [3:0]  addra;
  logic [15:0] dina;
  logic        wea0, wea1, rd_valid, rd_sel;
  logic        rd_release = 1'b0;
`ifdef BRAM_PP_STATUS_EN
  logic [15:0] bank_cnt;
  logic [0:0]  overrun_err;
`endif
  int          n_chk = 0;
  int          n_err = 0;
  int          stall_cnt = 0;
  logic        mon = 1'b0;
  logic [15:0] mem0 [0:15];
  logic [15:0] mem1 [0:15];
  logic        sel_q [$];

  bram_pingpong_ctrl dut (
    .clka(clka), .rst_na(rst_na), .flush(flush), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .addra(addra), .dina(dina), .wea0(wea0), .wea1(wea1),
    .rd_valid(rd_valid), .rd_sel(rd_sel), .rd_release(rd_release)
`ifdef BRAM_PP_STATUS_EN
    , .bank_cnt(bank_cnt), .overrun_err(overrun_err)
`endif
  );

  always #5 clka = ~clka;

  // bank model: stores on the edge after the write is issued
  always @(posedge clka) begin
    if (wea0) mem0[addra] <= dina;
    if (wea1) mem1[addra] <= dina;
  end

  always @(negedge clka) if (mon && s_valid && !s_ready) stall_cnt++;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic send(input logic [15:0] d);
    int n = 0;
    s_valid = 1'b1;
    s_data  = d;
    forever begin
      @(negedge clka);
      if (s_ready) break;
      if (++n > 100) begin
        chk("send_timeout", 1, 0);
        s_valid = 1'b0;
        return;
      end
    end
    @(posedge clka);
    #1 s_valid = 1'b0;
  endtask

  task automatic release_bank();
    rd_release = 1'b1;
    @(posedge clka);
    #1 rd_release = 1'b0;
  endtask

  task automatic do_reset();
    rst_na = 1'b0;
    #2;
    @(posedge clka);
    #1 rst_na = 1'b1;
  endtask

  initial begin
    #12;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_addra", addra, 0);
    chk("rst_dina", dina, 0);
    chk("rst_wea", {wea0, wea1}, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_sel", rd_sel, 0);
    @(posedge clka);
    #1 rst_na = 1'b1;
    // 1: fill bank 0
    for (int i = 1; i <= 11; i++) send(16'(i));
    chk("t1_wea0", wea0, 1);
    chk("t1_addra", addra, 10);
    chk("t1_dina", dina, 16'h000B);
    chk("t1_rdv_early", rd_valid, 0);
    @(posedge clka);
    #1;
    chk("t1_rd_valid", rd_valid, 1);
    chk("t1_rd_sel", rd_sel, 0);
    chk("t1_wea0_off", wea0, 0);
    chk("t1_mem0_0", mem0[0], 16'h0001);
    chk("t1_mem0_10", mem0[10], 16'h000B);
    // 2: fill bank 1, then stall
    for (int i = 12; i <= 22; i++) send(16'(i));
    chk("t2_wea1", wea1, 1);
    chk("t2_s_ready", s_ready, 0);
    @(posedge clka);
    #1;
    chk("t2_rd_valid", rd_valid, 1);
    chk("t2_rd_sel", rd_sel, 0);
    chk("t2_mem1_0", mem1[0], 16'h000C);
    chk("t2_mem1_10", mem1[10], 16'h0016);
    s_valid = 1'b1;
    s_data  = 16'h0017;
    repeat (3) @(posedge clka);
    #1;
    chk("t2_hold_wea", {wea0, wea1}, 0);
    chk("t2_hold_ready", s_ready, 0);
`ifdef BRAM_PP_STATUS_EN
    chk("t6_overrun", overrun_err, 1);
`endif
    release_bank();
    chk("t2_rel_ready", s_ready, 1);
    chk("t2_rel_sel", rd_sel, 1);
    chk("t2_rel_valid", rd_valid, 1);
    chk("t2_rel_wea0", wea0, 0);
    @(posedge clka);
    #1 s_valid = 1'b0;
    chk("t2_w23", {wea0, addra, dina}, {1'b1, 4'd0, 16'h0017});
`ifdef BRAM_PP_STATUS_EN
    chk("t6_cnt1", bank_cnt, 1);
`endif
    // 3: reset mid-fill, then continuous stream with prompt consumer
    do_reset();
    mon = 1'b1;
    fork
      for (int i = 0; i < 44; i++) send(16'h0100 + 16'(i));
      repeat (56) begin
        @(posedge clka);
        #1;
        if (rd_valid && !rd_release) begin
          sel_q.push_back(rd_sel);
          rd_release = 1'b1;
        end else rd_release = 1'b0;
      end
    join
    rd_release = 1'b0;
    mon = 1'b0;
    chk("t3_no_bubble", stall_cnt, 0);
    chk("t3_nrel", sel_q.size(), 4);
    if (sel_q.size() == 4) chk("t3_seq", {sel_q[0], sel_q[1], sel_q[2], sel_q[3]}, 4'b0101);
    chk("t3_mem0_0", mem0[0], 16'h0116);
    chk("t3_mem1_10", mem1[10], 16'h012B);
    chk("t3_idle", rd_valid, 0);
    // 4: release with nothing valid is ignored
    release_bank();
    chk("t4_sel", rd_sel, 0);
    chk("t4_valid", rd_valid, 0);
    chk("t4_ready", s_ready, 1);
    // 5: flush after 5 beats, refill bank 0
    for (int i = 0; i < 5; i++) send(16'h0200 + 16'(i));
    s_valid = 1'b1;
    s_data  = 16'hDEAD;
    flush   = 1'b1;
    @(negedge clka);
    chk("t5_flush_ready", s_ready, 0);
    @(posedge clka);
    #1;
    flush   = 1'b0;
    s_valid = 1'b0;
    chk("t5_flush_wea", {wea0, wea1}, 0);
    chk("t5_hold_addr", {addra, dina}, {4'd4, 16'h0204});
    for (int i = 0; i < 11; i++) send(16'h0300 + 16'(i));
    chk("t5_last", {wea0, addra}, {1'b1, 4'd10});
    chk("t5_rdv_early", rd_valid, 0);
    @(posedge clka);
    #1;
    chk("t5_rd_valid", {rd_valid, rd_sel}, 2'b10);
    chk("t5_mem0_0", mem0[0], 16'h0300);
    chk("t5_mem0_10", mem0[10], 16'h030A);
`ifdef BRAM_PP_STATUS_EN
    // 6: counter and sticky error, cleared by flush
    do_reset();
    for (int i = 0; i < 22; i++) send(16'(i));
    s_valid = 1'b1;
    repeat (2) @(posedge clka);
    #1 s_valid = 1'b0;
    chk("t6_ovr", overrun_err, 1);
    release_bank();
    release_bank();
    for (int i = 0; i < 11; i++) send(16'(i));
    @(posedge clka);
    #1 release_bank();
    chk("t6_cnt3", bank_cnt, 3);
    flush = 1'b1;
    @(posedge clka);
    #1 flush = 1'b0;
    chk("t6_flush", {bank_cnt, overrun_err}, 17'd0);
`endif
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
